// File: rtl/l2_request_queue.sv
// l2_request_queue: circular request FIFO between the L1 controller and L2.
// Accepted requests are queued in order and issued one at a time to L2. An
// issued command stays on command_out/address_out until L2 acknowledges it.
// NOP requests are accepted but dropped.
// Optional feature: define L2_REQ_COALESCE_EN to merge a Read into the
// queue tail when the tail is a Read or RWITM to the same line address.
module l2_request_queue #(
  parameter int ADDR_W = 26,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic [1:0]               req_cmd,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     req_ready,
  output logic [1:0]               command_out,
  output logic [ADDR_W-1:0]        address_out,
  input  logic                     l2_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RWITM = 2'b11
  } cmd_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

  // Queue storage; contents are only meaningful between the pointers.
  logic [1:0]        cmd_mem  [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        cmd_out_q, cmd_out_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic              busy_q, busy_d;

  logic accept;
  logic pop;
  logic coalesce;
  logic enq;

  assign req_ready   = (count_q < CNT_W'(DEPTH));
  assign count       = count_q;
  assign busy        = busy_q;
  assign command_out = cmd_out_q;
  assign address_out = addr_out_q;

  // Handshake decode: accept from L1, pop of the head toward the output registers.
  always_comb begin
    accept = req_valid && req_ready;
    pop    = (count_q != '0) && ((state_q == S_IDLE) || l2_ack);
  end

`ifdef L2_REQ_COALESCE_EN
  logic [PTR_W-1:0] tail_ptr;
  logic             tail_live;

  // A Read merges into the tail only if the tail survives this edge (not popped now).
  always_comb begin
    tail_ptr  = wr_ptr_q - PTR_W'(1);
    tail_live = (count_q > CNT_W'(1)) || ((count_q == CNT_W'(1)) && !pop);
    coalesce  = accept && (req_cmd == CMD_READ) && tail_live &&
                (addr_mem[tail_ptr] == req_addr) &&
                ((cmd_mem[tail_ptr] == CMD_READ) || (cmd_mem[tail_ptr] == CMD_RWITM));
  end
`else
  assign coalesce = 1'b0;
`endif

  assign enq = accept && (req_cmd != CMD_NOP) && !coalesce;

  // Next-state logic for pointers, occupancy and the issue FSM with its outputs.
  always_comb begin
    wr_ptr_d   = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(enq) - CNT_W'(pop);
    state_d    = state_q;
    cmd_out_d  = cmd_out_q;
    addr_out_d = addr_out_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d    = S_ISSUE;
          cmd_out_d  = cmd_mem[rd_ptr_q];
          addr_out_d = addr_mem[rd_ptr_q];
        end else begin
          cmd_out_d  = CMD_NOP;
          addr_out_d = '0;
        end
      end
      S_ISSUE: begin
        if (l2_ack) begin
          if (pop) begin
            cmd_out_d  = cmd_mem[rd_ptr_q];
            addr_out_d = addr_mem[rd_ptr_q];
          end else begin
            state_d    = S_IDLE;
            cmd_out_d  = CMD_NOP;
            addr_out_d = '0;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        cmd_out_d  = CMD_NOP;
        addr_out_d = '0;
      end
    endcase

    busy_d = (state_d == S_ISSUE);
  end

  // Control state and registered outputs; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cmd_out_q  <= CMD_NOP;
      addr_out_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cmd_out_q  <= cmd_out_d;
      addr_out_q <= addr_out_d;
      busy_q     <= busy_d;
    end
  end

  // Queue storage write; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      cmd_mem[wr_ptr_q]  <= req_cmd;
      addr_mem[wr_ptr_q] <= req_addr;
    end
  end

endmodule
